// File: rtl/z80_mem_arbiter_if.sv
// Bus bundle between the Z80 CPU wrapper, the video fetch unit and the RAM port.
// slave = arbiter side, master = surrounding environment side.
interface z80_mem_arbiter_if;
  logic        cpu_mreq_n;
  logic        cpu_rd_n;
  logic        cpu_wr_n;
  logic        cpu_rfsh_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_di;
  logic        cpu_wait_n;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [15:0] wait_cnt;

  modport slave (
    input  cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_a, cpu_dout,
    input  vid_req, vid_addr, mem_rdata,
    output cpu_di, cpu_wait_n, vid_ack, vid_data,
    output mem_req, mem_we, mem_addr, mem_wdata, wait_cnt
  );

  modport master (
    output cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_a, cpu_dout,
    output vid_req, vid_addr, mem_rdata,
    input  cpu_di, cpu_wait_n, vid_ack, vid_data,
    input  mem_req, mem_we, mem_addr, mem_wdata, wait_cnt
  );
endinterface

// File: rtl/z80_mem_arbiter.sv
// Shares one synchronous memory port between the Z80 bus and a video fetch requester.
// Optional stall statistics counter on wait_cnt is built when ARB_WAIT_CNT_EN is defined.
module z80_mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int VID_MAX = 4
) (
  input logic                clk,
  input logic                reset_n,
  z80_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CPU_ACC, VID_ACC} state_t;

  localparam logic [2:0] LAST_CNT    = 3'(MEM_LAT - 1);
  localparam logic [3:0] VID_MAX_L   = 4'(VID_MAX);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg;
  logic        served_reg;
  logic [3:0]  vid_run_reg;
  logic [7:0]  cpu_di_reg;
  logic [7:0]  vid_data_reg;
  logic        vid_ack_reg;
  logic        mem_we_reg;
  logic [15:0] mem_addr_reg;
  logic [7:0]  mem_wdata_reg;

  logic cpu_act;
  logic last_cyc;
  logic free;
  logic cpu_cand;
  logic grant_vid;
  logic grant_cpu;

  // State register and the datapath registers loaded at grant / completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      served_reg    <= 1'b0;
      vid_run_reg   <= 4'd0;
      cpu_di_reg    <= 8'h00;
      vid_data_reg  <= 8'h00;
      vid_ack_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 16'h0000;
      mem_wdata_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      vid_ack_reg <= 1'b0;

      if (grant_vid || grant_cpu)
        cnt_reg <= 3'd0;
      else if (state_reg != IDLE)
        cnt_reg <= cnt_reg + 3'd1;

      if (grant_vid) begin
        mem_addr_reg <= bus.vid_addr;
        mem_we_reg   <= 1'b0;
        if (!cpu_act)
          vid_run_reg <= 4'd0;
        else if (vid_run_reg != 4'hF)
          vid_run_reg <= vid_run_reg + 4'd1;
      end else if (grant_cpu) begin
        mem_addr_reg  <= bus.cpu_a;
        mem_we_reg    <= !bus.cpu_wr_n;
        mem_wdata_reg <= bus.cpu_dout;
        vid_run_reg   <= 4'd0;
      end else if (last_cyc) begin
        mem_we_reg <= 1'b0;
      end

      // A CPU that already dropped its strobe gets nothing back.
      if (last_cyc && state_reg == CPU_ACC && !mem_we_reg && !bus.cpu_mreq_n)
        cpu_di_reg <= bus.mem_rdata;

      if (last_cyc && state_reg == VID_ACC) begin
        vid_data_reg <= bus.mem_rdata;
        vid_ack_reg  <= 1'b1;
      end

      if (bus.cpu_mreq_n)
        served_reg <= 1'b0;
      else if (last_cyc && state_reg == CPU_ACC)
        served_reg <= 1'b1;
    end
  end

  // Grant decision happens in IDLE and again on the completion cycle, so
  // back-to-back accesses need no idle gap.
  always_comb begin
    last_cyc   = (state_reg != IDLE) && (cnt_reg == LAST_CNT);
    free       = (state_reg == IDLE) || last_cyc;
    cpu_cand   = cpu_act && !(state_reg == CPU_ACC && last_cyc);
    grant_vid  = free && bus.vid_req && (!cpu_cand || vid_run_reg < VID_MAX_L);
    grant_cpu  = free && cpu_cand && !grant_vid;
    state_next = state_reg;
    if (grant_vid)
      state_next = VID_ACC;
    else if (grant_cpu)
      state_next = CPU_ACC;
    else if (free)
      state_next = IDLE;
  end

  always_comb begin
    cpu_act = !bus.cpu_mreq_n && bus.cpu_rfsh_n
              && (!bus.cpu_rd_n || !bus.cpu_wr_n) && !served_reg;
  end

  assign bus.cpu_wait_n = !cpu_act;
  assign bus.mem_req    = (state_reg != IDLE);
  assign bus.mem_we     = mem_we_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
  assign bus.cpu_di     = cpu_di_reg;
  assign bus.vid_data   = vid_data_reg;
  assign bus.vid_ack    = vid_ack_reg;

`ifdef ARB_WAIT_CNT_EN
  logic [15:0] wait_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset_n)
      wait_cnt_reg <= 16'h0000;
    else if (cpu_act && wait_cnt_reg != 16'hFFFF)
      wait_cnt_reg <= wait_cnt_reg + 16'd1;
  end

  assign bus.wait_cnt = wait_cnt_reg;
`else
  assign bus.wait_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_z80_mem_arbiter.sv
// Directed scenarios followed by a random phase, every cycle checked against a
// transaction-level model of owner / remaining-cycle bookkeeping.
module tb_z80_mem_arbiter;
  localparam int MEM_LAT = 2;
  localparam int VID_MAX = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  z80_mem_arbiter_if bus();

  z80_mem_arbiter #(.MEM_LAT(MEM_LAT), .VID_MAX(VID_MAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Environment RAM driven by the DUT, and the model's own copy.
  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];

  always_comb bus.mem_rdata = bus.mem_req ? ram[bus.mem_addr] : 8'hEE;

  always @(posedge clk)
    if (bus.mem_req && bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;

  int n_pass = 0;
  int n_total = 0;

  // Model state: owner 0=none 1=cpu 2=video, cycles left in the access.
  int          own;
  int          left;
  int          m_run;
  logic [15:0] m_addr;
  logic        m_we;
  logic [7:0]  m_wdata;
  logic        m_served;
  logic [7:0]  m_di;
  logic [7:0]  m_vdata;
  logic        m_ack;
  logic [15:0] m_wait;

  int         obs_wait, obs_req, obs_ack, obs_wr;
  logic [7:0] last_vdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, want);
  endtask

  function automatic logic m_act();
    return !bus.cpu_mreq_n && bus.cpu_rfsh_n && (!bus.cpu_rd_n || !bus.cpu_wr_n) && !m_served;
  endfunction

  task automatic model_reset();
    own = 0; left = 0; m_run = 0; m_addr = 16'h0; m_we = 1'b0; m_wdata = 8'h0;
    m_served = 1'b0; m_di = 8'h0; m_vdata = 8'h0; m_ack = 1'b0; m_wait = 16'h0;
  endtask

  task automatic model_step();
    logic act, done, done_cpu, done_vid, cand, free;
    if (!reset_n) begin
      model_reset();
      return;
    end
    act = m_act();
`ifdef ARB_WAIT_CNT_EN
    if (act && m_wait != 16'hFFFF) m_wait = m_wait + 16'd1;
`endif
    done     = (own != 0) && (left == 1);
    done_cpu = done && own == 1;
    done_vid = done && own == 2;
    m_ack    = done_vid;
    if (done_vid) m_vdata = ref_mem[m_addr];
    if (done_cpu) begin
      if (m_we) ref_mem[m_addr] = m_wdata;
      else if (!bus.cpu_mreq_n) m_di = ref_mem[m_addr];
    end
    m_served = bus.cpu_mreq_n ? 1'b0 : (done_cpu ? 1'b1 : m_served);
    free = (own == 0) || done;
    cand = act && !done_cpu;
    if (!free) begin
      left--;
    end else if (bus.vid_req && (!cand || m_run < VID_MAX)) begin
      m_run = act ? ((m_run < 15) ? m_run + 1 : 15) : 0;
      own = 2; left = MEM_LAT; m_addr = bus.vid_addr; m_we = 1'b0;
    end else if (cand) begin
      m_run = 0;
      own = 1; left = MEM_LAT; m_addr = bus.cpu_a; m_we = !bus.cpu_wr_n; m_wdata = bus.cpu_dout;
    end else begin
      own = 0; m_we = 1'b0;
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    chk("cpu_wait_n", 32'(bus.cpu_wait_n), 32'(!m_act()));
    chk("mem_req",    32'(bus.mem_req),    32'(own != 0));
    if (own != 0) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      chk("mem_we",   32'(bus.mem_we),   32'(m_we));
      if (m_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
    end
    chk("vid_ack",  32'(bus.vid_ack),  32'(m_ack));
    chk("vid_data", 32'(bus.vid_data), 32'(m_vdata));
    chk("cpu_di",   32'(bus.cpu_di),   32'(m_di));
    chk("wait_cnt", 32'(bus.wait_cnt), 32'(m_wait));
    if (!bus.cpu_wait_n) obs_wait++;
    if (bus.mem_req) obs_req++;
    if (bus.vid_ack) begin
      obs_ack++;
      last_vdata = bus.vid_data;
    end
    if (bus.mem_req && bus.mem_we && bus.mem_addr == 16'h8000 && bus.mem_wdata == 8'h3C) obs_wr++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clr_obs();
    obs_wait = 0; obs_req = 0; obs_ack = 0; obs_wr = 0;
  endtask

  task automatic set_cpu(input logic mreq_n, input logic rd_n, input logic wr_n,
                         input logic rfsh_n, input logic [15:0] a, input logic [7:0] d);
    bus.cpu_mreq_n = mreq_n; bus.cpu_rd_n = rd_n; bus.cpu_wr_n = wr_n;
    bus.cpu_rfsh_n = rfsh_n; bus.cpu_a = a; bus.cpu_dout = d;
  endtask

  task automatic idle_cpu();
    set_cpu(1'b1, 1'b1, 1'b1, 1'b1, bus.cpu_a, bus.cpu_dout);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    ram[a] = d;
    ref_mem[a] = d;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 16'h1234;
      1:       return 16'h8000;
      2:       return 16'h4000;
      default: return 16'h00FF;
    endcase
  endfunction

  initial begin
    logic [7:0] rv;
    for (int i = 0; i < 65536; i++) begin
      rv = 8'($urandom);
      ram[i] = rv;
      ref_mem[i] = rv;
    end
    set_cpu(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
    bus.vid_req = 1'b0;
    bus.vid_addr = 16'h0000;
    clr_obs();

    // Reset
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    tick();
    reset_n = 1'b1;
    tick();

    // CPU-only read
    preload(16'h1234, 8'hA5);
    clr_obs();
    set_cpu(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 8'h00);
    repeat (5) tick();
    chk("rd_wait_cycles", 32'(obs_wait), 32'd3);
    chk("rd_req_cycles",  32'(obs_req),  32'd2);
    chk("rd_cpu_di",      32'(bus.cpu_di), 32'hA5);
    idle_cpu();
    tick();

    // CPU write
    clr_obs();
    set_cpu(1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 8'h3C);
    repeat (5) tick();
    chk("wr_wait_cycles", 32'(obs_wait), 32'd3);
    chk("wr_bus_cycles",  32'(obs_wr),   32'd2);
    chk("wr_cpu_di_kept", 32'(bus.cpu_di), 32'hA5);
    idle_cpu();
    tick();

    // Video-only fetch, request dropped once the ack is seen
    preload(16'h4000, 8'h77);
    clr_obs();
    bus.vid_req = 1'b1;
    bus.vid_addr = 16'h4000;
    for (int i = 0; i < 10 && obs_ack == 0; i++) tick();
    chk("vid_ack_seen", 32'(obs_ack), 32'd1);
    chk("vid_data_val", 32'(last_vdata), 32'h77);
    bus.vid_req = 1'b0;
    clr_obs();
    repeat (8) tick();
    chk("vid_inflight_acks", 32'(obs_ack), 32'd1);
    clr_obs();
    repeat (4) tick();
    chk("vid_no_more_req", 32'(obs_req), 32'd0);

    // Starvation limit: video held, CPU read arrives in the same cycle
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    clr_obs();
    bus.vid_req = 1'b1;
    bus.vid_addr = 16'h4000;
    set_cpu(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 8'h00);
    repeat (12) tick();
    chk("starve_wait_cycles", 32'(obs_wait), 32'd11);
    chk("starve_vid_acks",    32'(obs_ack),  32'd4);
    chk("starve_cpu_di",      32'(bus.cpu_di), 32'hA5);
    chk("starve_vid_resume",  32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, 16'h4000}));
`ifdef ARB_WAIT_CNT_EN
    chk("starve_wait_cnt", 32'(bus.wait_cnt), 32'd11);
`endif
    idle_cpu();
    bus.vid_req = 1'b0;
    repeat (6) tick();

    // Refresh cycle is ignored
    clr_obs();
    set_cpu(1'b0, 1'b1, 1'b1, 1'b0, 16'h2222, 8'h00);
    repeat (3) tick();
    chk("rfsh_req_cycles",  32'(obs_req),  32'd0);
    chk("rfsh_wait_cycles", 32'(obs_wait), 32'd0);
    idle_cpu();
    tick();

    // Reset during the second cycle of a video access
    bus.vid_req = 1'b1;
    bus.vid_addr = 16'h4000;
    tick();
    tick();
    reset_n = 1'b0;
    bus.vid_req = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst_mem_req",    32'(bus.mem_req),    32'd0);
    chk("rst_vid_ack",    32'(bus.vid_ack),    32'd0);
    chk("rst_cpu_wait_n", 32'(bus.cpu_wait_n), 32'd1);
    chk("rst_wait_cnt",   32'(bus.wait_cnt),   32'd0);
    repeat (3) tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      if (bus.vid_req) begin
        if (m_ack || $urandom_range(0, 15) == 0) bus.vid_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.vid_req = 1'b1;
        bus.vid_addr = pick_addr();
      end
      if (!bus.cpu_mreq_n) begin
        if (m_act()) begin
          if ($urandom_range(0, 31) == 0) idle_cpu();
        end else if ($urandom_range(0, 1) == 0) begin
          idle_cpu();
        end
      end else if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    set_cpu(1'b0, 1'b0, 1'b1, 1'b1, pick_addr(), 8'h00);
          2:       set_cpu(1'b0, 1'b1, 1'b0, 1'b1, pick_addr(), 8'($urandom));
          default: set_cpu(1'b0, 1'b1, 1'b1, 1'b0, pick_addr(), 8'h00);
        endcase
      end
      reset_n = !(own != 1 && $urandom_range(0, 99) == 0);
      tick();
    end
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/z80_mem_arbiter.md
Name: z80_mem_arbiter

Overview:
- Shares one synchronous memory port between the Z80 CPU bus (TV80-style mreq_n/rd_n/wr_n strobes) and a video fetch requester.
- Holds the CPU off with wait_n while video owns the port. Returns read data to either side.
- Sits between the CPU core wrapper, the video fetch unit and the RAM controller.

Parameters:
- MEM_LAT, 2: memory read latency in clk cycles from mem_req assertion to valid mem_rdata; legal 1..7.
- VID_MAX, 4: maximum consecutive video grants while a CPU access is pending; legal 1..15.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- cpu_mreq_n  in  1  CPU memory request strobe
- cpu_rd_n  in  1  CPU read strobe
- cpu_wr_n  in  1  CPU write strobe
- cpu_rfsh_n  in  1  CPU refresh indicator; low = refresh, ignored
- cpu_a  in  16  CPU address
- cpu_dout  in  8  CPU write data
- cpu_di  out  8  read data to CPU, registered
- cpu_wait_n  out  1  wait to CPU; low = stall
- vid_req  in  1  video fetch request, level; held with vid_addr stable until vid_ack
- vid_addr  in  16  video fetch address
- vid_ack  out  1  one-cycle pulse; vid_data valid in the same cycle
- vid_data  out  8  video read data, registered
- mem_req  out  1  memory access strobe
- mem_we  out  1  write enable, valid while mem_req
- mem_addr  out  16  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data
- wait_cnt  out  16  stall-cycle statistics (see Optional Feature)

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE; cpu_di=0, vid_data=0, vid_ack=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_wait_n=1, served=0, vid_run=0, wait_cnt=0.
- Reset mid-access aborts the access. No ack or data update occurs.
- CPU request (comb): cpu_act = !cpu_mreq_n & cpu_rfsh_n & (!cpu_rd_n | !cpu_wr_n) & !served.
- served sets when a CPU access completes. It clears on the first cycle cpu_mreq_n is high.
- cpu_wait_n = !cpu_act, combinational. It goes low in the same cycle the request appears and stays low until the completion cycle.
- States: IDLE, CPU_ACC, VID_ACC.
- IDLE grant rule, same cycle both requests present:
  - Video wins if vid_run < VID_MAX.
  - Otherwise CPU wins.
  - Single requester is granted directly.
  - Grant takes effect at the next edge.
- On entering an ACC state: mem_req=1; mem_addr is latched from cpu_a or vid_addr.
- CPU write: mem_we = !cpu_wr_n and mem_wdata = cpu_dout, both latched at grant.
- An access occupies exactly MEM_LAT cycles with mem_req held high. A 3-bit counter counts them.
- On the last cycle mem_rdata is captured:
  - CPU: into cpu_di. served=1 at the same edge, so cpu_wait_n returns high the following cycle.
  - Video: into vid_data. vid_ack=1 for the next cycle.
- Writes complete in the same MEM_LAT cycles. cpu_di is not updated on writes.
- Return to IDLE after the access. No idle gap is required: if a request is pending at the completion edge, the next grant goes directly to the next ACC state.
- vid_run:
  - increments (saturating at 15) on each video grant made while cpu_act is high;
  - clears on any CPU grant, and whenever cpu_act is low at a video grant.
- vid_req deasserted before its grant: no access. Deasserted mid-access: the access completes and vid_ack is still pulsed.
- CPU strobe released mid-access (illegal while waited): the access completes, and the data is discarded if cpu_mreq_n is high.

Optional Feature:
- Macro ARB_WAIT_CNT_EN.
- Defined: wait_cnt increments by 1 every clk with cpu_wait_n low. It saturates at 16'hFFFF and clears only on reset.
- Undefined: wait_cnt is tied to 16'h0000 and no counter logic is built.

Test Plan:
- CPU-only read, MEM_LAT=2, mem[16'h1234]=8'hA5, CPU read at 16'h1234 -> cpu_wait_n low for exactly 3 cycles; mem_req high for 2 cycles with mem_addr=16'h1234; cpu_di=8'hA5.
- CPU write 8'h3C to 16'h8000 -> mem_we=1, mem_wdata=8'h3C, mem_addr=16'h8000 for 2 cycles; cpu_di unchanged.
- Video-only, vid_req held with vid_addr=16'h4000, mem=8'h77 -> vid_ack single-cycle pulse with vid_data=8'h77; no further access after vid_req drops.
- Starvation, VID_MAX=4, vid_req held continuously plus a CPU read:
  - 4 video grants, then 1 CPU grant, then video resumes;
  - cpu_wait_n low for 4*2+2+1=11 cycles.
- Refresh cycle (cpu_rfsh_n=0, cpu_mreq_n=0, rd_n=1) -> no mem_req, cpu_wait_n stays 1.
- reset_n low during the 2nd cycle of a video access:
  - the next cycle shows mem_req=0, vid_ack=0, cpu_wait_n=1;
  - with ARB_WAIT_CNT_EN, the starvation case above gives wait_cnt=11 and reset gives 0.
